// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point adder/subtractor with valid/ready handshakes
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   operand handshake; op (0 add, 1 subtract), a, b = {sign, exp, man}
//   out_valid, out_ready result handshake; result, overflow, underflow, invalid held until taken
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 invalid
);
    localparam int XLEN = 1 + EXP_W + MAN_W;
    // significand: hidden bit, stored mantissa, one guard bit
    localparam int SW = MAN_W + 2;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [XLEN-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t           state_q;
    logic [XLEN-1:0]  a_q, b_q;
    logic             sign_q, sub_q;
    logic [EXP_W-1:0] exp_q;
    logic [SW-1:0]    sig_l_q, sig_s_q;
    logic [SW:0]      sum_q;

    logic [EXP_W-1:0] ea, eb, l_exp, s_exp, diff;
    logic [MAN_W-1:0] ma, mb;
    logic [SW-1:0]    sig_a, sig_b, l_sig, s_sig, al_sig;
    logic             a_ge, l_sign, a_inf, b_inf, special, nan_out, inf_sign;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;

    always_comb begin
        ea       = a_q[XLEN-2:MAN_W];
        eb       = b_q[XLEN-2:MAN_W];
        // a zero exponent flushes the operand to zero, mantissa included
        ma       = ea == '0 ? '0 : a_q[MAN_W-1:0];
        mb       = eb == '0 ? '0 : b_q[MAN_W-1:0];
        sig_a    = ea == '0 ? '0 : {1'b1, ma, 1'b0};
        sig_b    = eb == '0 ? '0 : {1'b1, mb, 1'b0};
        a_ge     = {ea, ma} >= {eb, mb};
        l_sign   = a_ge ? a_q[XLEN-1] : b_q[XLEN-1];
        l_exp    = a_ge ? ea : eb;
        s_exp    = a_ge ? eb : ea;
        l_sig    = a_ge ? sig_a : sig_b;
        s_sig    = a_ge ? sig_b : sig_a;
        diff     = l_exp - s_exp;
        al_sig   = 32'(diff) > MAN_W + 1 ? '0 : s_sig >> diff;
        a_inf    = ea == EMAX;
        b_inf    = eb == EMAX;
        special  = a_inf | b_inf;
        nan_out  = (a_inf & |a_q[MAN_W-1:0]) | (b_inf & |b_q[MAN_W-1:0]) |
                   (a_inf & b_inf & (a_q[XLEN-1] ^ b_q[XLEN-1]));
        inf_sign = a_inf ? a_q[XLEN-1] : b_q[XLEN-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            sub_q     <= 1'b0;
            exp_q     <= '0;
            sig_l_q   <= '0;
            sig_s_q   <= '0;
            sum_q     <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= {b[XLEN-1] ^ op, b[XLEN-2:0]};
                    state_q <= ALIGN;
                end
                ALIGN: begin
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                    invalid   <= 1'b0;
                    if (special) begin
                        result  <= nan_out ? QNAN : {inf_sign, EMAX, {MAN_W{1'b0}}};
                        invalid <= nan_out;
                        state_q <= DONE;
                    end else begin
                        sign_q  <= l_sign;
                        exp_q   <= l_exp;
                        sig_l_q <= l_sig;
                        sig_s_q <= al_sig;
                        sub_q   <= a_q[XLEN-1] ^ b_q[XLEN-1];
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sum_q   <= sub_q ? {1'b0, sig_l_q} - {1'b0, sig_s_q} : {1'b0, sig_l_q} + {1'b0, sig_s_q};
                    state_q <= NORM;
                end
                NORM: begin
                    if (sum_q == '0) begin
                        result  <= '0;
                        state_q <= DONE;
                    end else if (sum_q[SW]) begin
                        if (exp_q == EMAX - EXP_W'(1)) begin
                            result   <= {sign_q, EMAX, {MAN_W{1'b0}}};
                            overflow <= 1'b1;
                        end else begin
                            result <= {sign_q, exp_q + EXP_W'(1), sum_q[SW-1:2]};
                        end
                        state_q <= DONE;
                    end else if (sum_q[SW-1]) begin
                        result  <= {sign_q, exp_q, sum_q[MAN_W:1]};
                        state_q <= DONE;
                    end else if (exp_q == EXP_W'(1)) begin
                        result    <= {sign_q, {(XLEN-1){1'b0}}};
                        underflow <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        // finish in the same cycle the shift brings the hidden bit up
                        sum_q <= {sum_q[SW-1:0], 1'b0};
                        exp_q <= exp_q - EXP_W'(1);
                        if (sum_q[SW-2]) begin
                            result  <= {sign_q, exp_q - EXP_W'(1), sum_q[MAN_W-1:0]};
                            state_q <= DONE;
                        end
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: directed-vector bench for fp_addsub_seq
module tb_fp_addsub_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow, underflow, invalid;

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] r;
        logic [2:0]  f;
        logic [7:0]  lat;
    } vec_t;

    // f = {overflow, underflow, invalid}
    localparam vec_t ARITH [11] = '{
        '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 8'd4},
        '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 8'd4},
        '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 3'b000, 8'd4},
        '{32'h00000000, 32'h40200000, 1'b0, 32'h40200000, 3'b000, 8'd4},
        '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3'b000, 8'd4},
        '{32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 3'b000, 8'd4},
        '{32'h3F800000, 32'hC0400000, 1'b0, 32'hC0000000, 3'b000, 8'd4},
        '{32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 3'b000, 8'd4},
        '{32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 3'b000, 8'd5},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 8'd4},
        '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b010, 8'd4}
    };

    localparam vec_t SPECIAL [6] = '{
        '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001, 8'd2},
        '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, 8'd2},
        '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001, 8'd2},
        '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000, 8'd2},
        '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 3'b000, 8'd2},
        '{32'hFF800000, 32'h7F800000, 1'b0, 32'h7FC00000, 3'b001, 8'd2}
    };

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    always #5 clk = ~clk;

    // lat counts edges from the accepting edge (as 1) to the edge that raises out_valid
    task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input logic xop, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            nerr++;
            $display("FAIL in_ready_wait: in_ready still 0 after %0d cycles", guard);
        end
        in_valid = 1'b1;
        a = xa;
        b = xb;
        op = xop;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        op = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        nvec++;
        if ({in_ready, out_valid} !== 2'b10) begin
            nerr++;
            $display("FAIL reset_handshake: in_ready/out_valid=%b want 10", {in_ready, out_valid});
        end
        nvec++;
        if ({result, overflow, underflow, invalid} !== 35'd0) begin
            nerr++;
            $display("FAIL reset_outputs: result=%h flags=%b want 0/000", result, {overflow, underflow, invalid});
        end
    endtask

    task automatic test_arith();
        int lat;
        for (int i = 0; i < 11; i++) begin
            issue(ARITH[i].a, ARITH[i].b, ARITH[i].op, lat);
            nvec++;
            if (result !== ARITH[i].r) begin
                nerr++;
                $display("FAIL arith%0d result: got %h want %h", i, result, ARITH[i].r);
            end
            nvec++;
            if ({overflow, underflow, invalid} !== ARITH[i].f) begin
                nerr++;
                $display("FAIL arith%0d flags: got %b want %b", i, {overflow, underflow, invalid}, ARITH[i].f);
            end
            nvec++;
            if (lat !== int'(ARITH[i].lat)) begin
                nerr++;
                $display("FAIL arith%0d latency: got %0d want %0d", i, lat, ARITH[i].lat);
            end
            pop();
        end
    endtask

    task automatic test_special();
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(SPECIAL[i].a, SPECIAL[i].b, SPECIAL[i].op, lat);
            nvec++;
            if (result !== SPECIAL[i].r) begin
                nerr++;
                $display("FAIL special%0d result: got %h want %h", i, result, SPECIAL[i].r);
            end
            nvec++;
            if ({overflow, underflow, invalid} !== SPECIAL[i].f) begin
                nerr++;
                $display("FAIL special%0d flags: got %b want %b", i, {overflow, underflow, invalid}, SPECIAL[i].f);
            end
            nvec++;
            if (lat !== int'(SPECIAL[i].lat)) begin
                nerr++;
                $display("FAIL special%0d latency: got %0d want %0d", i, lat, SPECIAL[i].lat);
            end
            pop();
        end
    endtask

    task automatic test_long_norm_stall();
        int lat;
        issue(32'h3F800001, 32'h3F800000, 1'b1, lat);
        nvec++;
        if (result !== 32'h34000000 || lat !== 26) begin
            nerr++;
            $display("FAIL long_norm: result=%h lat=%0d want 34000000 lat=26", result, lat);
        end
        // junk offered while busy must be ignored
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 32'h40400000 + i;
            b = 32'h3F800000;
            op = i[0];
            @(posedge clk);
            #1;
            nvec++;
            if ({out_valid, in_ready, result, overflow, underflow, invalid} !== {2'b10, 32'h34000000, 3'b000}) begin
                nerr++;
                $display("FAIL stall%0d: out_valid=%b in_ready=%b result=%h want 1 0 34000000", i, out_valid, in_ready, result);
            end
        end
        in_valid = 1'b0;
        pop();
        nvec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            nerr++;
            $display("FAIL after_pop: out_valid/in_ready=%b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset_in_norm();
        int lat;
        bit seen = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h3F800001;
        b = 32'h3F800000;
        op = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        nvec++;
        if ({out_valid, in_ready, result} !== {2'b01, 32'h0}) begin
            nerr++;
            $display("FAIL reset_norm: out_valid=%b in_ready=%b result=%h want 0 1 00000000", out_valid, in_ready, result);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        nvec++;
        if (seen !== 1'b0) begin
            nerr++;
            $display("FAIL reset_discard: out_valid seen=%b want 0", seen);
        end
        issue(32'h40400000, 32'h3F800000, 1'b1, lat);
        nvec++;
        if (result !== 32'h40000000 || {overflow, underflow, invalid} !== 3'b000 || lat !== 4) begin
            nerr++;
            $display("FAIL post_reset_txn: result=%h flags=%b lat=%0d want 40000000 000 4", result, {overflow, underflow, invalid}, lat);
        end
        pop();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_arith();
        test_special();
        test_long_norm_stall();
        test_reset_in_norm();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
